// File: rtl/tl_timed_seq.sv
// rtl/tl_timed_seq.sv - timed phase sequencer for a two-road traffic light
//
// Holds the phase state {q1,q0} and a dwell counter.
// It decides when to leave green, using minimum/maximum green times.
// Yellow lasts a fixed number of cycles.
// A hold input freezes the phase and the counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   Ta, Tb    in   traffic present on road A / road B
//   hold      in   freeze phase and counter
//   q1, q0    out  registered phase state
//   La1, La0  out  road A light code (00 green, 01 yellow, 10 red)
//   Lb1, Lb0  out  road B light code
//   sw_pulse  out  high for the first cycle of each new phase
module tl_timed_seq #(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_LEN = 2,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic Ta,
    input  logic Tb,
    input  logic hold,
    output logic q1,
    output logic q0,
    output logic La1,
    output logic La0,
    output logic Lb1,
    output logic Lb0,
    output logic sw_pulse
);

    typedef enum logic [1:0] {
        S0 = 2'b00,   // A green,  B red
        S1 = 2'b01,   // A yellow, B red
        S2 = 2'b10,   // A red,    B green
        S3 = 2'b11    // A red,    B yellow
    } state_t;

    // The counter saturates at the longest dwell it ever has to measure.
    localparam int CNT_TOP = (GREEN_MAX > YELLOW_LEN) ? GREEN_MAX : YELLOW_LEN;

    localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_LEN - 1);
    localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(CNT_TOP - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sw_pulse;

    state_t           w_next_state;
    logic             w_advance;
    logic             w_min_done;
    logic             w_max_done;

    assign w_min_done = (r_cnt >= C_GMIN);
    assign w_max_done = (r_cnt >= C_GMAX);

    // A green phase yields only when the other road is waiting.
    // It yields early if its own road is empty.
    // Otherwise it yields once the maximum green time is reached.
    // Traffic inputs are looked at only on this edge; past requests are not remembered.
    always_comb begin
        w_advance    = 1'b0;
        w_next_state = r_state;
        unique case (r_state)
            S0: if (w_min_done && Tb && (!Ta || w_max_done)) begin
                w_advance    = 1'b1;
                w_next_state = S1;
            end
            S1: if (r_cnt == C_YEL) begin
                w_advance    = 1'b1;
                w_next_state = S2;
            end
            S2: if (w_min_done && Ta && (!Tb || w_max_done)) begin
                w_advance    = 1'b1;
                w_next_state = S3;
            end
            S3: if (r_cnt == C_YEL) begin
                w_advance    = 1'b1;
                w_next_state = S0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S0;
            r_cnt      <= '0;
            r_sw_pulse <= 1'b0;
        end else if (hold) begin
            // State and count are frozen; no new phase can start while held.
            r_sw_pulse <= 1'b0;
        end else if (w_advance) begin
            r_state    <= w_next_state;
            r_cnt      <= '0;
            r_sw_pulse <= 1'b1;
        end else begin
            if (r_cnt != C_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_sw_pulse <= 1'b0;
        end
    end

    assign q1       = r_state[1];
    assign q0       = r_state[0];
    assign La1      = r_state[1];
    assign La0      = ~r_state[1] & r_state[0];
    assign Lb1      = ~r_state[1];
    assign Lb0      = r_state[1] & r_state[0];
    assign sw_pulse = r_sw_pulse;

endmodule

// File: tb/tb_tl_timed_seq.sv
// tb/tb_tl_timed_seq.sv - directed, table-driven bench for tl_timed_seq
module tb_tl_timed_seq;

    logic clk;
    logic reset;
    logic Ta;
    logic Tb;
    logic hold;
    logic q1;
    logic q0;
    logic La1;
    logic La0;
    logic Lb1;
    logic Lb0;
    logic sw_pulse;

    int n_pass;
    int n_total;

    tl_timed_seq #(
        .GREEN_MIN (4),
        .GREEN_MAX (8),
        .YELLOW_LEN(2),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Ta      (Ta),
        .Tb      (Tb),
        .hold    (hold),
        .q1      (q1),
        .q0      (q0),
        .La1     (La1),
        .La0     (La0),
        .Lb1     (Lb1),
        .Lb0     (Lb0),
        .sw_pulse(sw_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ta;
        logic       tb;
        logic       hld;
        logic [1:0] q;
        logic       pulse;
        int         cnt;
    } vec_t;

    vec_t vecs[12];

    // Expected light codes per phase: A green/yellow/red/red, B red/red/green/yellow.
    logic [1:0] la_of[4];
    logic [1:0] lb_of[4];

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] eq, input logic ep, input int ec);
        check({tag, ".q"},     int'({q1, q0}),   int'(eq));
        check({tag, ".La"},    int'({La1, La0}), int'(la_of[eq]));
        check({tag, ".Lb"},    int'({Lb1, Lb0}), int'(lb_of[eq]));
        check({tag, ".pulse"}, int'(sw_pulse),   int'(ep));
        check({tag, ".cnt"},   int'(dut.r_cnt),  ec);
    endtask

    // Inputs are changed 1 time unit after a rising edge. Outputs are sampled 1 unit after the next rising edge.
    task automatic step(input logic r, input logic a, input logic b, input logic h);
        reset = r;
        Ta    = a;
        Tb    = b;
        hold  = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        la_of[0] = 2'b00; la_of[1] = 2'b01; la_of[2] = 2'b10; la_of[3] = 2'b10;
        lb_of[0] = 2'b10; lb_of[1] = 2'b10; lb_of[2] = 2'b00; lb_of[3] = 2'b01;
        reset = 1'b1;
        Ta    = 1'b0;
        Tb    = 1'b0;
        hold  = 1'b0;

        // Two reset cycles, then demand only on B.
        // S0 lasts 4 cycles and S1 lasts 2 cycles.
        // S2 then holds because A has no demand.
        //             rst   ta    tb    hld   q      pulse cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3};
        // Reset taken in S2 with cnt=3.
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].ta, vecs[i].tb, vecs[i].hld);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].pulse, vecs[i].cnt);
        end

        // Demand only on A: S0 holds, the count saturates at 7, and no pulse is produced.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("aonly%0d", k), 2'b00, 1'b0, (k > 7) ? 7 : k);
        end

        // Contention on both roads.
        // Phase lengths are S0 8, S1 2, S2 8 and S3 2, giving a period of 20.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int p = 1; p < 44; p++) begin
            int         m;
            logic [1:0] eq;
            int         ec;
            m = p % 20;
            if (m < 8) begin
                eq = 2'b00; ec = m;
            end else if (m < 10) begin
                eq = 2'b01; ec = m - 8;
            end else if (m < 18) begin
                eq = 2'b10; ec = m - 10;
            end else begin
                eq = 2'b11; ec = m - 18;
            end
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check_all($sformatf("both%0d", p), eq, (ec == 0), ec);
        end

        // Hold on entry to S1. State and cnt freeze and the pulse is suppressed.
        // After release, S1 finishes its remaining cycle and then moves to S2.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("hold_entry", 2'b01, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check_all($sformatf("held%0d", k), 2'b01, 1'b0, 0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("rel1", 2'b01, 1'b0, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("rel2", 2'b10, 1'b1, 0);

        // Hold in the middle of S2 keeps cnt at 1 while A has demand.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_all("hold_s2", 2'b10, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
